// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] data_a_in;
  logic [WIDTH-1:0] data_b_in;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_out;
  logic             carry_out;
  logic             zero_out;
  logic             neg_out;
  logic             ovf_out;

  modport master (
    output in_valid, op_code, data_a_in, data_b_in, carry_in, out_ready,
    input  in_ready, out_valid, result_out, carry_out, zero_out, neg_out, ovf_out
  );

  modport slave (
    input  in_valid, op_code, data_a_in, data_b_in, carry_in, out_ready,
    output in_ready, out_valid, result_out, carry_out, zero_out, neg_out, ovf_out
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with shifts, iterative multiply and registered C/Z/N/V flags
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NOTB = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_result;
  logic               r_c;
  logic               r_z;
  logic               r_n;
  logic               r_v;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_last;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sra;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.op_code == OP_MUL);
  assign w_last     = (r_state == S_BUSY) && (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept)           w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
        else if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shifts run one bit wider so the carry falls out as the extra bit; s=0 leaves it 0.
  assign w_a   = bus.data_a_in;
  assign w_b   = bus.data_b_in;
  assign w_sh  = w_b[SHW-1:0];
  assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, bus.carry_in};
  assign w_sub = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, bus.carry_in};
  assign w_shl = {1'b0, w_a} << w_sh;
  assign w_shr = {w_a, 1'b0} >> w_sh;
  assign w_sra = $signed({w_a, 1'b0}) >>> w_sh;

  always_comb begin
    w_res = w_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.op_code)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_add[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_sub[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOTA: w_res = ~w_a;
      OP_NOTB: w_res = ~w_b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      default: w_res = w_a;
    endcase
  end

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a};
        r_mplier <= w_b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_result <= w_res;
        r_c      <= w_c;
        r_v      <= w_v;
        r_z      <= (w_res == '0);
        r_n      <= w_res[WIDTH-1];
      end
    end else if (r_state == S_BUSY) begin
      // One multiplier bit per cycle; the final partial sum is taken straight from w_acc_nxt.
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (w_last) begin
        r_result <= w_acc_nxt[WIDTH-1:0];
        r_c      <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        r_v      <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        r_z      <= (w_acc_nxt[WIDTH-1:0] == '0);
        r_n      <= w_acc_nxt[WIDTH-1];
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.result_out = r_result;
  assign bus.carry_out  = r_c;
  assign bus.zero_out   = r_z;
  assign bus.neg_out    = r_n;
  assign bus.ovf_out    = r_v;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe with reference model and directed vectors
module tb_alu_pipe;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   n_out;

  alu_pipe_if #(.WIDTH(32)) bus ();

  alu_pipe #(.WIDTH(32)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] r;
    logic        c, z, n, v;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] r;
    logic        c, z, n, v;
  } vec_t;

  exp_t q[$];
  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    exp_t                e;
    logic [63:0]         wide;
    longint              ss;
    int                  s;
    e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0; e.r = a;
    s = int'(b[4:0]);
    case (op)
      4'd0: begin
        wide = 64'(a) + 64'(b) + 64'(cin);
        e.r  = wide[31:0];
        e.c  = wide[32];
        ss   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        e.v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1: begin
        e.r = a - b - 32'(cin);
        e.c = (64'(a) < 64'(b) + 64'(cin));
        ss  = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = ~a;
      4'd6: e.r = ~b;
      4'd7: begin
        e.r = a << s;
        if (s != 0) e.c = a[32 - s];
      end
      4'd8: begin
        e.r = a >> s;
        if (s != 0) e.c = a[s - 1];
      end
      4'd9: begin
        e.r = 32'($signed(a) >>> s);
        if (s != 0) e.c = a[s - 1];
      end
      4'd10: begin
        wide  = 64'(a) * 64'(b);
        e.r   = wide[31:0];
        e.c   = (wide[63:32] != 32'd0);
        e.v   = e.c;
        e.lat = 33;
      end
      default: e.r = a;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // Scoreboard: the head entry becomes visible once its latency has elapsed and stays until taken.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ov;
    if (!rst_n) begin
      q.delete();
    end else begin
      ov = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
      chk("mon_out_valid", 32'(bus.out_valid), 32'(ov));
      chk("mon_in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || (ov && bus.out_ready)));
      if (ov && bus.out_valid) begin
        chk("mon_result", bus.result_out, q[0].r);
        chk("mon_flags", {28'd0, bus.carry_out, bus.zero_out, bus.neg_out, bus.ovf_out},
            {28'd0, q[0].c, q[0].z, q[0].n, q[0].v});
        if (bus.out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.op_code, bus.data_a_in, bus.data_b_in, bus.carry_in);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic run_op(input string name, input vec_t t);
    int t0;
    int lo;
    bit got;
    bus.op_code   = t.op;
    bus.data_a_in = t.a;
    bus.data_b_in = t.b;
    bus.carry_in  = t.cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    t0 = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lo  = 0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else if (!bus.in_ready) lo++;
    end
    if (!got) chk({name, "_result_timeout"}, 32'd0, 32'd1);
    chk({name, "_latency"}, 32'(cyc - t0), (t.op == 4'd10) ? 32'd33 : 32'd1);
    if (t.op == 4'd10) chk({name, "_busy_cycles"}, 32'(lo), 32'd32);
    chk({name, "_r"}, bus.result_out, t.r);
    chk({name, "_czn_v"}, {28'd0, bus.carry_out, bus.zero_out, bus.neg_out, bus.ovf_out},
        {28'd0, t.c, t.z, t.n, t.v});
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int base;
    vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd1,  32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'd1,  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'd9,  32'h80000001, 32'h00000004, 1'b0, 32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd8,  32'h80000001, 32'h00000001, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd7,  32'h80000001, 32'h00000000, 1'b0, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'd10, 32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4'd10, 32'h00000007, 32'h00000006, 1'b0, 32'h0000002A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd2,  32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd6,  32'h12345678, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd13, 32'h12345678, 32'h00000009, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd0,  32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{4'd7,  32'h80000001, 32'h00000001, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'd1,  32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};

    n_chk = 0; n_fail = 0; n_out = 0; cyc = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op_code = 4'd0;
    bus.data_a_in = 32'd0; bus.data_b_in = 32'd0; bus.carry_in = 1'b0;
    #12;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_result", bus.result_out, 32'd0);
    chk("reset_flags", {28'd0, bus.carry_out, bus.zero_out, bus.neg_out, bus.ovf_out}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: ADD result held for 5 cycles, then XOR taken in the same cycle it drains.
    bus.op_code = 4'd0; bus.data_a_in = 32'd5; bus.data_b_in = 32'd3; bus.carry_in = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_r", bus.result_out, 32'd8);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.op_code = 4'd4; bus.data_a_in = 32'hF0F0F0F0; bus.data_b_in = 32'h0FF00FF0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_r", bus.result_out, 32'hFF00FF00);
    chk("b2b_neg", 32'(bus.neg_out), 32'd1);
    @(posedge clk);
    #1;

    base = n_out;
    for (int i = 0; i < 8; i++) begin
      bus.op_code = 4'd0; bus.data_a_in = 32'(i * 100); bus.data_b_in = 32'(i);
      bus.carry_in = 1'(i & 1); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("stream%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      if (i > 0) chk($sformatf("stream%0d_valid", i), 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", 32'(n_out - base), 32'd8);

    run_op("pre_reset_add", '{4'd0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    bus.op_code = 4'd10; bus.data_a_in = 32'd7; bus.data_b_in = 32'd6; bus.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midmul_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("midmul_rst_r", bus.result_out, 32'd0);
    chk("midmul_rst_flags", {28'd0, bus.carry_out, bus.zero_out, bus.neg_out, bus.ovf_out}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midmul_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midmul_release_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    run_op("post_reset", vecs[7]);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
